// File: rtl/vga_blit_engine.sv
// ============================================================================
// Module : vga_blit_engine
// Brief  : Wishbone command-queued blitter (char / rect / clear) that writes
//          palette-indexed pixels into an external framebuffer write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vga_blit_engine #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FONT_W     = 16,
    parameter int FONT_H     = 16,
    parameter int PIX_BITS   = 2,
    parameter int FIFO_DEPTH = 8,
    localparam int FB_AW     = $clog2(H_RES * V_RES)
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [7:0]                 wb_adr_i,
    input  logic [31:0]                wb_dat_i,
    output logic [31:0]                wb_dat_o,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic [7:0]                 font_addr,
    input  logic [FONT_W*FONT_H-1:0]   font_data,
    output logic                       fb_we,
    output logic [FB_AW-1:0]           fb_waddr,
    output logic [PIX_BITS-1:0]        fb_wdata,
    output logic                       irq_o
);

    localparam int FA_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W = FA_W + 1;
    localparam int EW    = 2 + 10 + 9 + 10 + 9 + 8 + 2 * PIX_BITS + 1;
    localparam int FI_W  = $clog2(FONT_W * FONT_H);
    localparam logic [1:0] OP_CHAR = 2'd1;
    localparam logic [1:0] OP_RECT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_ROM_WAIT = 3'd2,
        S_DRAW     = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t r_state, w_next;

    // ---------------- Wishbone front end and staging registers -------------
    logic        r_ack;
    logic [31:0] r_dat;
    logic [9:0]  r_pos_x, r_size_w;
    logic [8:0]  r_pos_y, r_size_h;
    logic [7:0]  r_ascii;
    logic [PIX_BITS-1:0] r_fg, r_bg;
    logic        r_transp, r_irq_en, r_irq_pend, r_ovf;

    logic        w_acc, w_wr;
    logic [2:0]  w_reg;
    assign w_acc = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr  = w_acc & wb_we_i;
    assign w_reg = wb_adr_i[4:2];

    // ---------------- command FIFO ----------------------------------------
    logic [EW-1:0]    r_fifo [FIFO_DEPTH];
    logic [FA_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic w_full, w_empty, w_push_req, w_push, w_pop, w_busy;
    logic [EW-1:0] w_new_entry;

    logic [1:0]  w_h_op;
    logic [9:0]  w_h_x, w_h_w;
    logic [8:0]  w_h_y, w_h_h;
    logic [7:0]  w_h_ascii;
    logic [PIX_BITS-1:0] w_h_fg, w_h_bg;
    logic        w_h_tr;

    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push_req  = w_wr && (w_reg == 3'd0) && (wb_dat_i[1:0] != 2'd0);
    assign w_push      = w_push_req & ~w_full;
    assign w_pop       = (r_state == S_FETCH);
    assign w_busy      = (r_state != S_IDLE) | ~w_empty;
    assign w_new_entry = {wb_dat_i[1:0], r_pos_x, r_pos_y, r_size_w, r_size_h,
                          r_ascii, r_fg, r_bg, r_transp};
    assign {w_h_op, w_h_x, w_h_y, w_h_w, w_h_h, w_h_ascii, w_h_fg, w_h_bg, w_h_tr}
           = r_fifo[r_rd_ptr];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_new_entry;
                r_wr_ptr         <= r_wr_ptr + FA_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + FA_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- render datapath -------------------------------------
    logic [1:0]  r_op;
    logic [9:0]  r_ox;
    logic [8:0]  r_oy;
    logic [10:0] r_ext_w, r_cx, w_ext_w;
    logic [9:0]  r_ext_h, r_cy, w_ext_h;
    logic [PIX_BITS-1:0] r_fg_c, r_bg_c;
    logic        r_tr_c;
    logic [7:0]  r_font_addr;

    logic        w_last_x, w_last, w_in, w_is_char, w_glyph_bit, w_draw_we;
    logic [11:0] w_px;
    logic [10:0] w_py;
    logic [FI_W-1:0]  w_bit_idx;
    logic [FB_AW-1:0] w_addr;

    always_comb begin
        w_ext_w = 11'(H_RES);
        w_ext_h = 10'(V_RES);
        case (w_h_op)
            OP_CHAR: begin
                w_ext_w = 11'(FONT_W);
                w_ext_h = 10'(FONT_H);
            end
            OP_RECT: begin
                w_ext_w = {1'b0, w_h_w};
                w_ext_h = {1'b0, w_h_h};
            end
            default: ;
        endcase
    end

    assign w_last_x    = (r_cx == r_ext_w - 11'd1);
    assign w_last      = w_last_x && (r_cy == r_ext_h - 10'd1);
    // One extra bit on each coordinate sum keeps off-screen pixels from wrapping.
    assign w_px        = 12'(r_ox) + 12'(r_cx);
    assign w_py        = 11'(r_oy) + 11'(r_cy);
    assign w_in        = (w_px < 12'(H_RES)) && (w_py < 11'(V_RES));
    assign w_is_char   = (r_op == OP_CHAR);
    assign w_bit_idx   = FI_W'(int'(r_cy) * FONT_W + int'(r_cx));
    assign w_glyph_bit = font_data[w_bit_idx];
    assign w_draw_we   = (r_state == S_DRAW) && w_in &&
                         (!w_is_char || w_glyph_bit || !r_tr_c);
    assign w_addr      = FB_AW'(int'(w_py) * H_RES + int'(w_px));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (!w_empty) w_next = S_FETCH;
            S_FETCH: begin
                if (w_h_op == OP_CHAR)
                    w_next = S_ROM_WAIT;
                else if ((w_h_op == OP_RECT) && ((w_h_w == 10'd0) || (w_h_h == 9'd0)))
                    w_next = S_DONE;
                else
                    w_next = S_DRAW;
            end
            S_ROM_WAIT: w_next = S_DRAW;
            S_DRAW:     if (w_last) w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_ext_w     <= '0;
            r_ext_h     <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_fg_c      <= '0;
            r_bg_c      <= '0;
            r_tr_c      <= 1'b0;
            r_font_addr <= '0;
            fb_we       <= 1'b0;
            fb_waddr    <= '0;
            fb_wdata    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) begin
                r_op        <= w_h_op;
                r_ox        <= (w_h_op == 2'd3) ? 10'd0 : w_h_x;
                r_oy        <= (w_h_op == 2'd3) ? 9'd0 : w_h_y;
                r_ext_w     <= w_ext_w;
                r_ext_h     <= w_ext_h;
                r_cx        <= '0;
                r_cy        <= '0;
                r_fg_c      <= w_h_fg;
                r_bg_c      <= w_h_bg;
                r_tr_c      <= w_h_tr;
                r_font_addr <= w_h_ascii - 8'h20;
            end else if (r_state == S_DRAW) begin
                if (w_last_x) begin
                    r_cx <= '0;
                    r_cy <= r_cy + 10'd1;
                end else begin
                    r_cx <= r_cx + 11'd1;
                end
            end
            fb_we <= w_draw_we;
            if (w_draw_we) begin
                fb_waddr <= w_addr;
                fb_wdata <= (w_is_char && w_glyph_bit) ? r_fg_c : r_bg_c;
            end
        end
    end

    // ---------------- register file ---------------------------------------
    logic [31:0] w_rdata, w_status, w_attr;
    assign w_status = {23'd0, r_ovf, 4'(r_count), 1'b0, w_empty, w_full, w_busy};
    assign w_attr   = 32'(r_ascii) | (32'(r_fg) << 8) | (32'(r_bg) << 12) |
                      (32'(r_transp) << 16);

    always_comb begin
        w_rdata = 32'd0;
        case (w_reg)
            3'd1:    w_rdata = w_status;
            3'd2:    w_rdata = {7'd0, r_pos_y, 6'd0, r_pos_x};
            3'd3:    w_rdata = {7'd0, r_size_h, 6'd0, r_size_w};
            3'd4:    w_rdata = w_attr;
            3'd5:    w_rdata = {31'd0, r_irq_en};
            3'd6:    w_rdata = {31'd0, r_irq_pend};
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_pos_x    <= '0;
            r_pos_y    <= '0;
            r_size_w   <= '0;
            r_size_h   <= '0;
            r_ascii    <= '0;
            r_fg       <= '0;
            r_bg       <= '0;
            r_transp   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_irq_pend <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_ack <= wb_cyc_i & wb_stb_i & ~r_ack;
            r_dat <= w_acc ? w_rdata : 32'd0;
            if (w_wr) begin
                case (w_reg)
                    3'd2: begin
                        r_pos_x <= wb_dat_i[9:0];
                        r_pos_y <= wb_dat_i[24:16];
                    end
                    3'd3: begin
                        r_size_w <= wb_dat_i[9:0];
                        r_size_h <= wb_dat_i[24:16];
                    end
                    3'd4: begin
                        r_ascii  <= wb_dat_i[7:0];
                        r_fg     <= wb_dat_i[8 +: PIX_BITS];
                        r_bg     <= wb_dat_i[12 +: PIX_BITS];
                        r_transp <= wb_dat_i[16];
                    end
                    3'd5:    r_irq_en <= wb_dat_i[0];
                    default: ;
                endcase
            end
            // A full-FIFO push sets overflow even if a pop frees a slot this cycle.
            if (w_push_req && w_full)
                r_ovf <= 1'b1;
            else if (w_wr && (w_reg == 3'd1) && wb_dat_i[8])
                r_ovf <= 1'b0;
            if (r_state == S_DONE)
                r_irq_pend <= 1'b1;
            else if (w_wr && (w_reg == 3'd6) && wb_dat_i[0])
                r_irq_pend <= 1'b0;
        end
    end

    logic w_unused;
    assign w_unused = ^{wb_adr_i, wb_dat_i};

    assign wb_ack_o  = r_ack;
    assign wb_dat_o  = r_dat;
    assign wb_err_o  = 1'b0;
    assign font_addr = r_font_addr;
    assign irq_o     = r_irq_pend & r_irq_en;

endmodule

`default_nettype wire

// File: tb/tb_vga_blit_engine.sv
// ============================================================================
// Module : tb_vga_blit_engine
// Brief  : Self-checking bench for vga_blit_engine (table + random + corners).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_vga_blit_engine;

    localparam int TB_H  = 640;
    localparam int TB_V  = 40;
    localparam int TB_AW = $clog2(TB_H * TB_V);

    logic         clk = 1'b0;
    logic         rst;
    logic         cyc, stb, we;
    logic [7:0]   adr;
    logic [31:0]  dat_w;
    logic [31:0]  dat_r;
    logic         ack, err;
    logic [7:0]   font_addr;
    logic [255:0] font_data;
    logic         fb_we;
    logic [TB_AW-1:0] fb_waddr;
    logic [1:0]   fb_wdata;
    logic         irq;

    int n_vec = 0;
    int n_bad = 0;

    logic [255:0] font_mem [256];
    logic [31:0]  q_got [$];
    logic [31:0]  q_exp [$];

    vga_blit_engine #(
        .H_RES(TB_H), .V_RES(TB_V), .FONT_W(16), .FONT_H(16),
        .PIX_BITS(2), .FIFO_DEPTH(8)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(dat_r),
        .wb_ack_o(ack), .wb_err_o(err), .font_addr(font_addr),
        .font_data(font_data), .fb_we(fb_we), .fb_waddr(fb_waddr),
        .fb_wdata(fb_wdata), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial font_data = '0;
    always @(posedge clk) font_data <= font_mem[font_addr];

    always @(negedge clk)
        if (fb_we) q_got.push_back((32'(fb_waddr) << 8) | 32'(fb_wdata));

    typedef struct {
        int op, x, y, w, h, asc, fg, bg, tr;
        int exp_n, exp_cyc;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        @(posedge clk);
        @(negedge clk);
        d = dat_r;
        cyc = 1'b0; stb = 1'b0;
    endtask

    // Reference: walk the extent row-major and emit every visible pixel.
    task automatic model_cmd(input int op, x, y, w, h, asc, fg, bg, tr);
        int ww, hh, ox, oy, px, py;
        logic [255:0] g;
        ox = x; oy = y; ww = w; hh = h;
        if (op == 3) begin ox = 0; oy = 0; ww = TB_H; hh = TB_V; end
        else if (op == 1) begin ww = 16; hh = 16; end
        g = font_mem[(asc - 32) & 255];
        for (int cy = 0; cy < hh; cy++)
            for (int cx = 0; cx < ww; cx++) begin
                px = ox + cx; py = oy + cy;
                if (px < TB_H && py < TB_V) begin
                    if (op != 1)
                        q_exp.push_back(32'((py * TB_H + px) << 8) | 32'(bg));
                    else if (g[cy * 16 + cx])
                        q_exp.push_back(32'((py * TB_H + px) << 8) | 32'(fg));
                    else if (tr == 0)
                        q_exp.push_back(32'((py * TB_H + px) << 8) | 32'(bg));
                end
            end
    endtask

    function automatic int model_cycles(input int op, w, h);
        if (op == 1) return 1 + 1 + 256 + 1;
        if (op == 3) return 1 + TB_H * TB_V + 1;
        if (w == 0 || h == 0) return 2;
        return 1 + w * h + 1;
    endfunction

    task automatic compare_lists(input string nm);
        int nmin, idx;
        check({nm, " count"}, q_got.size(), q_exp.size());
        nmin = (q_got.size() < q_exp.size()) ? q_got.size() : q_exp.size();
        idx = 0;
        for (int k = 0; k < nmin; k++)
            if (q_got[k] !== q_exp[k]) begin idx = k; break; end
        if (nmin > 0) check({nm, " data"}, q_got[idx], q_exp[idx]);
    endtask

    task automatic run_cmd(input int op, x, y, w, h, asc, fg, bg, tr,
                           input int exp_n, input int exp_cyc, input string nm);
        int n;
        wb_write(8'h08, 32'((y << 16) | x));
        wb_write(8'h0C, 32'((h << 16) | w));
        wb_write(8'h10, 32'(asc | (fg << 8) | (bg << 12) | (tr << 16)));
        wb_write(8'h18, 32'd1);
        q_got.delete(); q_exp.delete();
        model_cmd(op, x, y, w, h, asc, fg, bg, tr);
        wb_write(8'h00, 32'(op));
        n = 0;
        while (n < exp_cyc + 100) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (irq) break;
        end
        check({nm, " cycles"}, n - 1, exp_cyc);
        repeat (2) @(negedge clk);
        if (exp_n >= 0) check({nm, " writes"}, q_got.size(), exp_n);
        compare_lists(nm);
    endtask

    initial begin
        logic [31:0] rd;
        int op, x, y, w, h, asc, fg, bg, tr, iter;
        int rect_addr [6];

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0;
        for (int a = 0; a < 256; a++)
            for (int k = 0; k < 8; k++) font_mem[a][k * 32 +: 32] = $urandom();
        for (int i = 0; i < 256; i++) font_mem[33][i] = 1'(((i % 16) + (i / 16)) % 2);

        rect_addr = '{2568, 2569, 2570, 3208, 3209, 3210};
        tbl[0] = '{2, 8, 4, 3, 2, 0, 0, 2, 0, 6, 8};
        tbl[1] = '{1, 0, 0, 0, 0, 8'h41, 3, 1, 1, 128, 259};
        tbl[2] = '{1, 0, 0, 0, 0, 8'h41, 3, 1, 0, 256, 259};
        tbl[3] = '{1, 632, 32, 0, 0, 8'h41, 3, 1, 0, 64, 259};
        tbl[4] = '{2, 5, 5, 0, 5, 0, 0, 1, 0, 0, 2};
        tbl[5] = '{2, 5, 5, 7, 0, 0, 0, 1, 0, 0, 2};
        tbl[6] = '{2, 636, 38, 10, 5, 0, 0, 3, 0, 8, 52};
        tbl[7] = '{3, 9, 9, 0, 0, 0, 0, 3, 0, TB_H * TB_V, 2 + TB_H * TB_V};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst fb_we", fb_we, 1'b0);
        check("rst irq", irq, 1'b0);
        check("rst err", err, 1'b0);
        wb_read(8'h04, rd); check("rst status", rd, 32'h004);
        wb_read(8'h08, rd); check("rst pos", rd, 32'h0);

        // Reset in the middle of a long RECT must stop all writes at once.
        wb_write(8'h08, 32'h0);
        wb_write(8'h0C, (32'd20 << 16) | 32'd100);
        wb_write(8'h10, 32'h1000);
        wb_write(8'h00, 32'd2);
        repeat (30) @(negedge clk);
        check("pre-rst drawing", (q_got.size() > 0) ? 1 : 0, 1);
        #2 rst = 1'b1;
        #1 check("midrst fb_we", fb_we, 1'b0);
        q_got.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst writes", q_got.size(), 0);
        wb_read(8'h04, rd); check("midrst status", rd, 32'h004);
        check("midrst irq", irq, 1'b0);

        wb_write(8'h14, 32'd1);
        wb_write(8'h08, (32'd7 << 16) | 32'd123);
        wb_read(8'h08, rd); check("pos readback", rd, (32'd7 << 16) | 32'd123);

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].asc,
                    tbl[i].fg, tbl[i].bg, tbl[i].tr, tbl[i].exp_n, tbl[i].exp_cyc,
                    $sformatf("tbl%0d", i));
            if (i == 0)
                for (int k = 0; k < 6; k++)
                    check("rect addr", (k < q_got.size()) ? q_got[k] : 32'hFFFFFFFF,
                          (32'(rect_addr[k]) << 8) | 32'd2);
        end

        wb_read(8'h18, rd); check("irq_pend", rd, 32'd1);
        wb_write(8'h14, 32'd0); check("irq masked", irq, 1'b0);
        wb_write(8'h14, 32'd1); check("irq unmasked", irq, 1'b1);
        wb_write(8'h18, 32'd1); check("irq w1c", irq, 1'b0);

        wb_write(8'h00, 32'd0);
        wb_read(8'h04, rd); check("nop status", rd, 32'h004);

        // Overflow: one long RECT starts, the next 8 fill the FIFO, the 9th drops.
        q_got.delete(); q_exp.delete();
        wb_write(8'h08, 32'h0);
        wb_write(8'h0C, (32'd5 << 16) | 32'd100);
        wb_write(8'h10, 32'h1000);
        wb_write(8'h00, 32'd2);
        model_cmd(2, 0, 0, 100, 5, 0, 0, 1, 0);
        wb_write(8'h0C, (32'd1 << 16) | 32'd2);
        wb_write(8'h10, 32'h2000);
        for (int k = 1; k <= 9; k++) begin
            wb_write(8'h08, (32'd10 << 16) | 32'(k * 4));
            wb_write(8'h00, 32'd2);
            if (k <= 8) model_cmd(2, k * 4, 10, 2, 1, 0, 0, 2, 0);
        end
        wb_read(8'h04, rd); check("ovf status", rd, 32'h183);
        iter = 0;
        rd = 32'h1;
        while (rd[0] && iter < 3000) begin
            wb_read(8'h04, rd);
            iter++;
        end
        check("ovf drain", rd[0], 1'b0);
        compare_lists("ovf order");
        wb_read(8'h04, rd); check("ovf sticky", rd, 32'h104);
        wb_write(8'h04, 32'h100);
        wb_read(8'h04, rd); check("ovf w1c", rd, 32'h004);

        for (int r = 0; r < 20; r++) begin
            op  = $urandom_range(1, 2);
            x   = $urandom_range(0, 650);
            y   = $urandom_range(0, 45);
            w   = $urandom_range(0, 12);
            h   = $urandom_range(0, 6);
            asc = $urandom_range(32, 127);
            fg  = $urandom_range(0, 3);
            bg  = $urandom_range(0, 3);
            tr  = $urandom_range(0, 1);
            run_cmd(op, x, y, w, h, asc, fg, bg, tr, -1, model_cycles(op, w, h),
                    $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
